uart_alu_interface: RTL and testbench

- Sequential front/back end for the ALU. Collects three bytes from the UART receiver: operand A, operand B, then opcode.
- Drives those bytes as registered operands into the ALU, captures the combinational result, and hands it to the UART transmitter.
- Sits between uart_rx/uart_tx and the ALU in the board-level top.

---
 rtl/alu_if_pkg.sv | 25 ++
 rtl/uart_alu_interface.sv | 136 +++++++++++++
 tb/tb_uart_alu_interface.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_if_pkg.sv
// Shared definitions for the UART/ALU bridge: FSM state encoding and ALU opcodes.
package alu_if_pkg;

    typedef enum logic [2:0] {
        WAIT_A   = 3'd0,
        WAIT_B   = 3'd1,
        WAIT_OP  = 3'd2,
        CALC     = 3'd3,
        SEND     = 3'd4,
        WAIT_TX  = 3'd5,
        SEND_C   = 3'd6,
        WAIT_TXC = 3'd7
    } state_e;

    // Funct-style ALU opcodes, shared with the ALU and the bench
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from uart_rx, drives the ALU, returns the result via uart_tx.
// Optional UART_ALU_CARRY_TX_EN: sends a second byte holding the ALU carry after the result.
module uart_alu_interface
    import alu_if_pkg::*;
#(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned OP_BITS = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [SIZE-1:0]    i_rx_data,
    input  logic               i_rx_done,
    input  logic [SIZE-1:0]    i_alu_res,
    input  logic               i_alu_carry,
    input  logic               i_tx_done,
    output logic [SIZE-1:0]    o_a_alu,
    output logic [SIZE-1:0]    o_b_alu,
    output logic [OP_BITS-1:0] o_opcode_alu,
    output logic [SIZE-1:0]    o_tx_data,
    output logic               o_tx_start
);

    state_e               state_q, state_d;
    logic [SIZE-1:0]      a_q, a_d;
    logic [SIZE-1:0]      b_q, b_d;
    logic [OP_BITS-1:0]   op_q, op_d;
    logic [SIZE-1:0]      tx_q, tx_d;
    logic                 start_q, start_d;

`ifdef UART_ALU_CARRY_TX_EN
    logic                 carry_q, carry_d;
`else
    logic                 unused_carry;
    assign unused_carry = i_alu_carry;
`endif

    // State and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= '0;
            start_q <= 1'b0;
`ifdef UART_ALU_CARRY_TX_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            start_q <= start_d;
`ifdef UART_ALU_CARRY_TX_EN
            carry_q <= carry_d;
`endif
        end
    end

    // Next-state and register updates; start pulse is registered, so it is raised on entry to SEND/SEND_C
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        start_d = 1'b0;
`ifdef UART_ALU_CARRY_TX_EN
        carry_d = carry_q;
`endif
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[OP_BITS-1:0];
                    state_d = CALC;
                end
            end
            CALC: begin
                tx_d    = i_alu_res;
`ifdef UART_ALU_CARRY_TX_EN
                carry_d = i_alu_carry;
`endif
                start_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
`ifdef UART_ALU_CARRY_TX_EN
                    tx_d    = SIZE'(carry_q);
                    start_d = 1'b1;
                    state_d = SEND_C;
`else
                    state_d = WAIT_A;
`endif
                end
            end
`ifdef UART_ALU_CARRY_TX_EN
            SEND_C: begin
                state_d = WAIT_TXC;
            end
            WAIT_TXC: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
`endif
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    assign o_a_alu      = a_q;
    assign o_b_alu      = b_q;
    assign o_opcode_alu = op_q;
    assign o_tx_data    = tx_q;
    assign o_tx_start   = start_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface with a behavioural ALU and transaction-level reference.
module tb_uart_alu_interface;
    import alu_if_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_res;
    logic       alu_carry;
    logic       tx_done;
    logic [7:0] a_alu, b_alu, tx_data;
    logic [5:0] op_alu;
    logic       tx_start;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

`ifdef UART_ALU_CARRY_TX_EN
    localparam int unsigned BYTES_PER_OP = 2;
`else
    localparam int unsigned BYTES_PER_OP = 1;
`endif

    always #5 clk = ~clk;

    uart_alu_interface #(.SIZE(8), .OP_BITS(6)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_res    (alu_res),
        .i_alu_carry  (alu_carry),
        .i_tx_done    (tx_done),
        .o_a_alu      (a_alu),
        .o_b_alu      (b_alu),
        .o_opcode_alu (op_alu),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start)
    );

    // Behavioural ALU: {carry, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [7:0] sra;
        sra = 8'($signed(a) >>> b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOR:  return {1'b0, ~(a | b)};
            OP_SRA:  return {1'b0, sra};
            OP_SRL:  return {1'b0, a >> b};
            default: return 9'h000;
        endcase
    endfunction

    always_comb {alu_carry, alu_res} = alu_f(a_alu, b_alu, op_alu);

    always @(posedge clk) if (tx_start === 1'b1) start_cnt++;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        tick(gap);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // One full operation; drop_rx puts a 0x77 rx pulse on top of the result's tx_done
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input bit drop_rx, input bit gaps);
        logic [8:0] exp;
        int cnt0;
        exp = alu_f(a, b, opb[5:0]);
        send_byte(a, gaps ? $urandom_range(0, 3) : 0);
        send_byte(b, gaps ? $urandom_range(0, 3) : 0);
        cnt0 = start_cnt;
        send_byte(opb, gaps ? $urandom_range(0, 3) : 0);
        checks++;
        if (a_alu !== a || b_alu !== b || op_alu !== opb[5:0]) begin
            errors++;
            $display("FAIL operands: a=%h b=%h op=%h expected a=%h b=%h op=%h", a_alu, b_alu, op_alu, a, b, opb[5:0]);
        end
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL start_early: got %b expected 0", tx_start); end
        tick(1);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== exp[7:0]) begin
            errors++;
            $display("FAIL result: start=%b data=%h expected start=1 data=%h (a=%h b=%h op=%h)", tx_start, tx_data, exp[7:0], a, b, opb);
        end
        tick(1);
        checks++;
        if (tx_start !== 1'b0 || tx_data !== exp[7:0]) begin
            errors++;
            $display("FAIL start_width: start=%b data=%h expected start=0 data=%h", tx_start, tx_data, exp[7:0]);
        end
        tick($urandom_range(0, 4));
        tx_done = 1'b1;
        if (drop_rx) begin rx_data = 8'h77; rx_done = 1'b1; end
        tick(1);
        tx_done = 1'b0;
        rx_done = 1'b0;
`ifdef UART_ALU_CARRY_TX_EN
        checks++;
        if (tx_start !== 1'b1 || tx_data !== {7'd0, exp[8]}) begin
            errors++;
            $display("FAIL carry_byte: start=%b data=%h expected start=1 data=%h", tx_start, tx_data, {7'd0, exp[8]});
        end
        tick($urandom_range(1, 3));
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
`endif
        tick(1);
        checks++;
        if (start_cnt - cnt0 !== int'(BYTES_PER_OP)) begin
            errors++;
            $display("FAIL start_count: got %0d expected %0d", start_cnt - cnt0, BYTES_PER_OP);
        end
        checks++;
        if (a_alu !== a || b_alu !== b) begin
            errors++;
            $display("FAIL operand_hold: a=%h b=%h expected a=%h b=%h", a_alu, b_alu, a, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (a_alu !== 8'h00 || b_alu !== 8'h00 || op_alu !== 6'h00 || tx_data !== 8'h00 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: a=%h b=%h op=%h tx=%h start=%b expected all 0", a_alu, b_alu, op_alu, tx_data, tx_start);
        end
    endtask

    task automatic test_directed();
        run_op(8'h05, 8'h03, 8'h20, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'h22, 1'b0, 1'b0);
        run_op(8'hF0, 8'h3C, 8'hE4, 1'b0, 1'b0);
        run_op(8'hFF, 8'h02, 8'h20, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int cnt0;
        cnt0 = start_cnt;
        send_byte(8'h11, 0);
        checks++;
        if (a_alu !== 8'h11) begin errors++; $display("FAIL load_a: got %h expected 11", a_alu); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (a_alu !== 8'h00) begin errors++; $display("FAIL reset_clears_a: got %h expected 00", a_alu); end
        // Reset while in CALC must suppress the start pulse
        send_byte(8'h09, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        checks++;
        if (start_cnt !== cnt0 || a_alu !== 8'h00 || op_alu !== 6'h00) begin
            errors++;
            $display("FAIL reset_abort: starts=%0d a=%h op=%h expected starts=%0d a=00 op=00", start_cnt, a_alu, op_alu, cnt0);
        end
        run_op(8'h02, 8'h04, 8'h20, 1'b0, 1'b0);
    endtask

    task automatic test_drop();
        run_op(8'h10, 8'h20, 8'h25, 1'b1, 1'b0);
        // Stray tx_done while idle must not trigger anything
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        run_op(8'h41, 8'h0F, 8'h26, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [7:0] opb;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 5) opb = 8'($urandom);
            else opb = {2'($urandom), ops[$urandom_range(0, 7)]};
            run_op(8'($urandom), 8'($urandom), opb, ($urandom_range(0, 3) == 0), 1'b1);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick(1);
        test_reset();
        test_directed();
        test_mid_reset();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
